// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU operand-issue stage: default sizes and the
// opcode encodings the downstream ALU understands.
package alu_issue_stage_pkg;

    localparam int WORD_SIZE_DEF = 64;
    localparam int NREGS_DEF     = 16;

    typedef logic [3:0] alu_op_t;

    // Opcodes are forwarded untouched; these names exist for readability
    // and for the reset value of the opcode register.
    localparam alu_op_t OP_ADD = 4'b0000;
    localparam alu_op_t OP_SUB = 4'b0001;
    localparam alu_op_t OP_OR  = 4'b0011;
    localparam alu_op_t OP_AND = 4'b0100;
    localparam alu_op_t OP_SHL = 4'b1001;
    localparam alu_op_t OP_SHR = 4'b1010;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file for the issue stage: NREGS x WORD_SIZE, one synchronous write
// port fed by ALU writeback, two combinational read ports that see a
// same-cycle writeback through a bypass. r0 is hardwired to zero.
module issue_regfile
    import alu_issue_stage_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NREGS     = NREGS_DEF,
    localparam int REG_W    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [REG_W-1:0]     wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [REG_W-1:0]     rd_addr1,
    output logic [WORD_SIZE-1:0] rd_data1,
    input  logic [REG_W-1:0]     rd_addr2,
    output logic [WORD_SIZE-1:0] rd_data2
);

    logic [WORD_SIZE-1:0] regs [NREGS];

    // Storage update: writes to r0 are dropped so it keeps its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is reset on purpose: a reset drops all
            // architectural state, so this storage is flops, not a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: sequential state uses <= so every flop samples the
                // pre-edge values regardless of statement order.
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: r0 is zero, otherwise a matching writeback wins over storage.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (wr_en && wr_addr == rd_addr1) rd_data1 = wr_data;
        if (wr_en && wr_addr == rd_addr2) rd_data2 = wr_data;
        if (rd_addr1 == '0) rd_data1 = '0;
        if (rd_addr2 == '0) rd_data2 = '0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage in front of the ALU: reads sources from the register
// file, stalls on scoreboard hazards (RAW and WAW), and presents registered
// operands to the ALU through a valid/ready pipeline register.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NREGS     = NREGS_DEF,
    localparam int REG_W    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [REG_W-1:0]     in_rd,
    input  logic [REG_W-1:0]     in_rs1,
    input  logic [REG_W-1:0]     in_rs2,
    input  logic                 in_use_imm,
    input  logic [WORD_SIZE-1:0] in_imm,
    input  logic                 wb_en,
    input  logic [REG_W-1:0]     wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic [WORD_SIZE-1:0] alu_d1,
    output logic [WORD_SIZE-1:0] alu_d2,
    output logic [3:0]           alu_op,
    output logic [REG_W-1:0]     out_rd,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [NREGS-1:0]     pend;
    logic [NREGS-1:0]     wb_mask;
    logic [NREGS-1:0]     set_mask;
    logic [NREGS-1:0]     pend_eff;
    logic [WORD_SIZE-1:0] rs1_data;
    logic [WORD_SIZE-1:0] rs2_data;
    logic [WORD_SIZE-1:0] d2_sel;
    logic                 hz;
    logic                 accept;

    issue_regfile #(
        .WORD_SIZE (WORD_SIZE),
        .NREGS     (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd_addr1 (in_rs1),
        .rd_data1 (rs1_data),
        .rd_addr2 (in_rs2),
        .rd_data2 (rs2_data)
    );

    // Hazard detection and handshake: a pending bit being cleared by this
    // cycle's writeback no longer blocks issue.
    always_comb begin
        wb_mask  = '0;
        set_mask = '0;
        if (wb_en) wb_mask = NREGS'(1) << wb_addr;
        pend_eff = pend & ~wb_mask;
        hz       = pend_eff[in_rs1] | (!in_use_imm & pend_eff[in_rs2]) | pend_eff[in_rd];
        in_ready = rst_n & (!out_valid | out_ready) & !hz;
        accept   = in_valid & in_ready;
        if (accept && in_rd != '0) set_mask = NREGS'(1) << in_rd;
        d2_sel   = in_use_imm ? in_imm : rs2_data;
    end

    // Scoreboard: clear on writeback, set on issue; set wins on the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~wb_mask) | set_mask;
        end
    end

    // Pipeline register to the ALU: load on accept, drain on out_ready, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_d1    <= '0;
            alu_d2    <= '0;
            alu_op    <= OP_ADD;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_d1    <= rs1_data;
            alu_d2    <= d2_sel;
            alu_op    <= in_op;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: inputs change and outputs are sampled
// on the falling clock edge, well away from the active rising edge.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    localparam int W = 64;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [R-1:0] in_rd;
    logic [R-1:0] in_rs1;
    logic [R-1:0] in_rs2;
    logic         in_use_imm;
    logic [W-1:0] in_imm;
    logic         wb_en;
    logic [R-1:0] wb_addr;
    logic [W-1:0] wb_data;
    logic [W-1:0] alu_d1;
    logic [W-1:0] alu_d2;
    logic [3:0]   alu_op;
    logic [R-1:0] out_rd;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.WORD_SIZE(W), .NREGS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .alu_d1     (alu_d1),
        .alu_d2     (alu_d2),
        .alu_op     (alu_op),
        .out_rd     (out_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [R-1:0] rd, input logic [R-1:0] rs1,
                         input logic [R-1:0] rs2, input logic use_imm, input logic [W-1:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
    endtask

    task automatic wb(input logic [R-1:0] addr, input logic [W-1:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
    endtask

    // One full cycle: through the rising edge, back to the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_d1", alu_d1, 0);
        check("rst_d2", alu_d2, 0);
        check("rst_op", W'(alu_op), 0);
        check("rst_out_rd", W'(out_rd), 0);
        check("rst_pend", W'(dut.pend), 0);
        check("rst_in_ready", W'(in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Basic issue after loading r1/r2
        wb(1, 6);
        tick();
        wb(2, 7);
        tick();
        idle();
        issue(OP_ADD, 3, 1, 2, 1'b0, '0);
        #1;
        check("t1_in_ready", W'(in_ready), 1);
        tick();
        idle();
        check("t1_out_valid", W'(out_valid), 1);
        check("t1_d1", alu_d1, 6);
        check("t1_d2", alu_d2, 7);
        check("t1_op", W'(alu_op), 0);
        check("t1_out_rd", W'(out_rd), 3);
        check("t1_pend3", W'(dut.pend[3]), 1);

        // 2. RAW stall on r3, released by writeback with bypass
        issue(OP_SUB, 5, 3, 2, 1'b0, '0);
        #1;
        check("t2_stall0", W'(in_ready), 0);
        tick();
        check("t2_bubble", W'(out_valid), 0);
        #1;
        check("t2_stall1", W'(in_ready), 0);
        tick();
        wb(3, 13);
        #1;
        check("t2_wb_ready", W'(in_ready), 1);
        tick();
        idle();
        check("t2_d1_bypass", alu_d1, 13);
        check("t2_d2", alu_d2, 7);
        check("t2_op", W'(alu_op), W'(OP_SUB));
        check("t2_out_rd", W'(out_rd), 5);
        check("t2_pend3", W'(dut.pend[3]), 0);
        check("t2_pend5", W'(dut.pend[5]), 1);

        // 3. Backpressure holds outputs and blocks issue
        out_ready = 1'b0;
        issue(OP_OR, 6, 1, 2, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_in_ready_bp", W'(in_ready), 0);
            tick();
            check("t3_hold_d1", alu_d1, 13);
            check("t3_hold_op", W'(alu_op), W'(OP_SUB));
            check("t3_hold_valid", W'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", W'(in_ready), 1);
        tick();
        idle();
        check("t3_d1", alu_d1, 6);
        check("t3_d2", alu_d2, 7);
        check("t3_op", W'(alu_op), W'(OP_OR));
        check("t3_out_rd", W'(out_rd), 6);

        // 4. Immediate operand and r0 behaviour
        issue(OP_SHL, 7, 0, 0, 1'b1, 2);
        tick();
        idle();
        check("t4_d1", alu_d1, 0);
        check("t4_d2_imm", alu_d2, 2);
        check("t4_op", W'(alu_op), W'(OP_SHL));
        wb(0, 5);
        tick();
        idle();
        issue(OP_AND, 8, 0, 1, 1'b0, '0);
        wb(0, 9);
        tick();
        idle();
        check("t4_r0_zero", alu_d1, 0);
        check("t4_d2", alu_d2, 6);
        check("t4_pend0", W'(dut.pend[0]), 0);

        // 5. Invalid opcode passthrough, then same-cycle set/clear on r4
        issue(4'b1111, 4, 1, 2, 1'b0, '0);
        tick();
        idle();
        check("t5_op_f", W'(alu_op), 'hF);
        check("t5_pend4_a", W'(dut.pend[4]), 1);
        issue(OP_ADD, 4, 2, 1, 1'b0, '0);
        wb(4, 44);
        #1;
        check("t5_waw_ready", W'(in_ready), 1);
        tick();
        idle();
        check("t5_pend4_b", W'(dut.pend[4]), 1);
        check("t5_b2b_valid", W'(out_valid), 1);
        check("t5_d1", alu_d1, 7);
        check("t5_d2", alu_d2, 6);

        // 6. Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", W'(out_valid), 0);
        check("t6_pend", W'(dut.pend), 0);
        check("t6_in_ready", W'(in_ready), 0);
        check("t6_d1", alu_d1, 0);
        tick();
        rst_n = 1'b1;
        issue(OP_ADD, 9, 1, 2, 1'b0, '0);
        tick();
        idle();
        check("t6_regs_cleared", alu_d1, 0);
        check("t6_reissue_valid", W'(out_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
